// File: rtl/vga_timing_pkg.sv
// Shared timing constants, phase encoding and derived-total helper for the video timing path.
package vga_timing_pkg;

   localparam int unsigned DEF_HDISP  = 800;
   localparam int unsigned DEF_HFP    = 40;
   localparam int unsigned DEF_HPULSE = 48;
   localparam int unsigned DEF_HBP    = 40;
   localparam int unsigned DEF_VDISP  = 480;
   localparam int unsigned DEF_VFP    = 13;
   localparam int unsigned DEF_VPULSE = 3;
   localparam int unsigned DEF_VBP    = 29;

   typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

   function automatic int unsigned axis_total(input int unsigned disp, input int unsigned fp,
                                              input int unsigned pulse, input int unsigned bp);
      return disp + fp + pulse + bp;
   endfunction

   function automatic int unsigned htotal();
      return axis_total(DEF_HDISP, DEF_HFP, DEF_HPULSE, DEF_HBP);
   endfunction

   function automatic int unsigned vtotal();
      return axis_total(DEF_VDISP, DEF_VFP, DEF_VPULSE, DEF_VBP);
   endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One timing axis: wrapping position counter plus decoded phase; used for both H and V.
module sync_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned DISP  = DEF_HDISP,
   parameter int unsigned FP    = DEF_HFP,
   parameter int unsigned PULSE = DEF_HPULSE,
   parameter int unsigned BP    = DEF_HBP,
   localparam int unsigned TOTAL = axis_total(DISP, FP, PULSE, BP),
   localparam int unsigned W     = $clog2(TOTAL)
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output phase_t       phase,
   output logic         wrap
);

   logic [W-1:0] cnt_q, cnt_d;

   assign wrap = inc && (cnt_q == W'(TOTAL - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (wrap) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      if (cnt_q < W'(DISP)) begin
         phase = ACTIVE;
      end else if (cnt_q < W'(DISP + FP)) begin
         phase = FRONT;
      end else if (cnt_q < W'(DISP + FP + PULSE)) begin
         phase = SYNC;
      end else begin
         phase = BACK;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: H/V axis counters with registered sync, blank, coordinate and pulse outputs.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned HDISP  = DEF_HDISP,
   parameter int unsigned HFP    = DEF_HFP,
   parameter int unsigned HPULSE = DEF_HPULSE,
   parameter int unsigned HBP    = DEF_HBP,
   parameter int unsigned VDISP  = DEF_VDISP,
   parameter int unsigned VFP    = DEF_VFP,
   parameter int unsigned VPULSE = DEF_VPULSE,
   parameter int unsigned VBP    = DEF_VBP,
   localparam int unsigned XW = $clog2(HDISP),
   localparam int unsigned YW = $clog2(VDISP),
   localparam int unsigned HW = $clog2(axis_total(HDISP, HFP, HPULSE, HBP)),
   localparam int unsigned VW = $clog2(axis_total(VDISP, VFP, VPULSE, VBP))
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          en,
   output logic          vga_HS,
   output logic          vga_VS,
   output logic          vga_BLANK,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          pix_valid,
   output logic          line_start,
   output logic          frame_start
);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   phase_t        h_phase, v_phase;
   logic          h_wrap, v_wrap_unused;

   sync_axis_counter #(
      .DISP (HDISP),
      .FP   (HFP),
      .PULSE(HPULSE),
      .BP   (HBP)
   ) u_h_axis (
      .clk  (clk),
      .nrst (nrst),
      .clear(~en),
      .inc  (en),
      .cnt  (h_cnt),
      .phase(h_phase),
      .wrap (h_wrap)
   );

   sync_axis_counter #(
      .DISP (VDISP),
      .FP   (VFP),
      .PULSE(VPULSE),
      .BP   (VBP)
   ) u_v_axis (
      .clk  (clk),
      .nrst (nrst),
      .clear(~en),
      .inc  (h_wrap),
      .cnt  (v_cnt),
      .phase(v_phase),
      .wrap (v_wrap_unused)
   );

   logic          hs_q, hs_d, vs_q, vs_d, valid_q, valid_d;
   logic          ls_q, ls_d, fs_q, fs_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   // With en low every output takes its reset value, so a restart never shows a partial frame.
   always_comb begin
      hs_d    = 1'b1;
      vs_d    = 1'b1;
      valid_d = 1'b0;
      x_d     = '0;
      y_d     = '0;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
      if (en) begin
         hs_d    = (h_phase != SYNC);
         vs_d    = (v_phase != SYNC);
         valid_d = (h_phase == ACTIVE) && (v_phase == ACTIVE);
         if (valid_d) begin
            x_d = h_cnt[XW-1:0];
            y_d = v_cnt[YW-1:0];
         end
         ls_d = (h_cnt == '0) && (v_phase == ACTIVE);
         fs_d = (h_cnt == '0) && (v_cnt == '0);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
      end
   end

   assign vga_HS      = hs_q;
   assign vga_VS      = vs_q;
   assign vga_BLANK   = valid_q;
   assign pix_valid   = valid_q;
   assign pix_x       = x_q;
   assign pix_y       = y_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (15 clocks x 8 lines) to keep runs short.
module tb_vga_timing_gen;

   // Raster: H = 8+2+3+2 = 15 clocks, V = 4+1+2+1 = 8 lines, frame = 120 clocks.
   localparam int unsigned HDISP = 8, HFP = 2, HPULSE = 3, HBP = 2;
   localparam int unsigned VDISP = 4, VFP = 1, VPULSE = 2, VBP = 1;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       en = 1'b0;
   logic       vga_HS, vga_VS, vga_BLANK, pix_valid, line_start, frame_start;
   logic [2:0] pix_x;
   logic [1:0] pix_y;

   int n_total = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .HDISP (HDISP),
      .HFP   (HFP),
      .HPULSE(HPULSE),
      .HBP   (HBP),
      .VDISP (VDISP),
      .VFP   (VFP),
      .VPULSE(VPULSE),
      .VBP   (VBP)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .en         (en),
      .vga_HS     (vga_HS),
      .vga_VS     (vga_VS),
      .vga_BLANK  (vga_BLANK),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_valid  (pix_valid),
      .line_start (line_start),
      .frame_start(frame_start)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_hs"}, 32'(vga_HS), 1);
      check_eq({tag, "_vs"}, 32'(vga_VS), 1);
      check_eq({tag, "_blank"}, 32'(vga_BLANK), 0);
      check_eq({tag, "_valid"}, 32'(pix_valid), 0);
      check_eq({tag, "_xy"}, {27'd0, pix_y, pix_x}, 0);
      check_eq({tag, "_pulses"}, {30'd0, line_start, frame_start}, 0);
   endtask

   task automatic check_origin(input string tag);
      check_eq({tag, "_fs"}, 32'(frame_start), 1);
      check_eq({tag, "_ls"}, 32'(line_start), 1);
      check_eq({tag, "_valid"}, 32'(pix_valid), 1);
      check_eq({tag, "_blank"}, 32'(vga_BLANK), 1);
      check_eq({tag, "_xy"}, {27'd0, pix_y, pix_x}, 0);
   endtask

   initial begin
      int valid_cnt, line_cnt, fs_cnt, hs_low_first, vs_low, xerr, exp_x;
      int hs_fall0, hs_fall1, vs_fall, last_x, last_y, blank_err, idle_err, pulse_cnt;
      logic prev_hs, prev_vs;

      repeat (10) tick();
      check_idle("reset");

      nrst = 1'b1;
      en   = 1'b1;
      tick();
      check_origin("first");
      check_eq("first_hs", 32'(vga_HS), 1);
      check_eq("first_vs", 32'(vga_VS), 1);

      // One full frame, i = output cycle index within the frame (i=0 is the frame_start cycle).
      valid_cnt = 0; line_cnt = 0; fs_cnt = 0; hs_low_first = 0; vs_low = 0; xerr = 0;
      exp_x = 0; hs_fall0 = -1; hs_fall1 = -1; vs_fall = -1; last_x = 0; last_y = 0;
      blank_err = 0; idle_err = 0; prev_hs = 1'b1; prev_vs = 1'b1;
      for (int i = 0; i < 120; i++) begin
         if (frame_start) fs_cnt++;
         if (line_start) begin
            line_cnt++;
            exp_x = 0;
         end
         if (vga_BLANK !== pix_valid) blank_err++;
         if (pix_valid) begin
            valid_cnt++;
            if (pix_x != exp_x[2:0]) xerr++;
            exp_x++;
            last_x = int'(pix_x);
            last_y = int'(pix_y);
         end else if (pix_x != 0 || pix_y != 0) begin
            idle_err++;
         end
         if (prev_hs && !vga_HS) begin
            if (hs_fall0 < 0) hs_fall0 = i;
            else if (hs_fall1 < 0) hs_fall1 = i;
         end
         if (i < 15 && !vga_HS) hs_low_first++;
         if (!vga_VS) vs_low++;
         if (prev_vs && !vga_VS && vs_fall < 0) vs_fall = i;
         prev_hs = vga_HS;
         prev_vs = vga_VS;
         tick();
      end
      check_eq("frame_fs_count", fs_cnt, 1);
      check_eq("frame_line_starts", line_cnt, 4);
      check_eq("frame_valid_cycles", valid_cnt, 32);
      check_eq("frame_x_contiguous", xerr, 0);
      check_eq("frame_blank_eq_valid", blank_err, 0);
      check_eq("frame_xy_zero_idle", idle_err, 0);
      check_eq("last_pixel_x", last_x, 7);
      check_eq("last_pixel_y", last_y, 3);
      check_eq("hs_first_fall", hs_fall0, 10);
      check_eq("hs_period", hs_fall1 - hs_fall0, 15);
      check_eq("hs_low_width", hs_low_first, 3);
      check_eq("vs_low_width", vs_low, 30);
      check_eq("vs_fall", vs_fall, 75);
      check_origin("wrap");

      // en drop mid-frame while HS is low (line 2, column 11).
      repeat (41) tick();
      check_eq("pre_en_hs", 32'(vga_HS), 0);
      check_eq("pre_en_valid", 32'(pix_valid), 0);
      en = 1'b0;
      tick();
      check_idle("en_low");
      pulse_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (line_start || frame_start || pix_valid || !vga_HS || !vga_VS) pulse_cnt++;
      end
      check_eq("en_low_quiet", pulse_cnt, 0);
      en = 1'b1;
      tick();
      check_origin("en_resume");
      tick();
      check_eq("en_resume_x1", 32'(pix_x), 1);
      check_eq("en_resume_fs_gone", 32'(frame_start), 0);

      // Asynchronous reset mid-line: at column 5 of line 1.
      repeat (19) tick();
      check_eq("pre_rst_x", 32'(pix_x), 5);
      check_eq("pre_rst_y", 32'(pix_y), 1);
      #2;
      nrst = 1'b0;
      #1;
      check_idle("async_rst");
      repeat (3) @(posedge clk);
      #1;
      check_idle("rst_hold");
      nrst = 1'b1;
      tick();
      check_origin("rst_release");
      tick();
      check_eq("rst_release_x1", 32'(pix_x), 1);
      check_eq("rst_release_ls_gone", 32'(line_start), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
